// File: rtl/data_memory_responder_pkg.sv
// Shared types and defaults for the data-memory responder and its storage array.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_W               = 32;
  localparam int LAT_W                = 4;
  localparam int DMEM_DEPTH_DEFAULT   = 256;
  localparam int DMEM_LATENCY_DEFAULT = 2;

  function automatic logic misaligned_f(input logic [1:0] byte_off);
    return (byte_off != 2'b00);
  endfunction

endpackage

// File: rtl/data_memory_responder_array.sv
// DEPTH_WORDS x 32-bit data store: synchronous write, registered read.
// Contents are deliberately not reset so data survives a pipeline reset.
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_DEFAULT
) (
  input  logic                           clk,
  input  logic                           wr_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
  input  logic [WORD_W-1:0]              wr_data,
  input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
  output logic [WORD_W-1:0]              rd_data
);

  logic [WORD_W-1:0] mem_r [DEPTH_WORDS];

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_idx] <= wr_data;
    end
    rd_data <= mem_r[rd_idx];
  end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: one outstanding word load/store, completed after LATENCY wait states.
// Define DMEM_MISALIGN_CHECK_EN to flag and suppress accesses with req_addr[1:0] != 0.
module data_memory_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_DEFAULT,
  parameter int LATENCY     = DMEM_LATENCY_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              stall,
  output logic              misalign_err
);

  localparam int               AW    = $clog2(DEPTH_WORDS);
  localparam logic [LAT_W-1:0] LAT_C = LAT_W'(LATENCY);

  state_t            state_r, state_s;
  logic [LAT_W-1:0]  cnt_r, cnt_s;
  logic              accept_s;
  logic              write_r;
  logic [AW-1:0]     idx_r;
  logic [AW-1:0]     req_idx_s;
  logic [AW-1:0]     rd_idx_s;
  logic [WORD_W-1:0] wdata_r;
  logic [WORD_W-1:0] rd_data_s;
  logic              misalign_r, misalign_s;
  logic              in_resp_s;
  logic              wr_en_s;
  logic              unused_s;

  // Upper address bits alias onto the array; low bits are only a byte offset.
  assign req_idx_s = req_addr[AW+1:2];
  assign unused_s  = ^{req_addr[WORD_W-1:AW+2], req_addr[1:0]};

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign_s = misaligned_f(req_addr[1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  // State and wait-state counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= {LAT_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Request capture; inputs are only looked at in the accept cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_r    <= 1'b0;
      idx_r      <= {AW{1'b0}};
      wdata_r    <= {WORD_W{1'b0}};
      misalign_r <= 1'b0;
    end else if (accept_s) begin
      write_r    <= req_write;
      idx_r      <= req_idx_s;
      wdata_r    <= req_wdata;
      misalign_r <= misalign_s;
    end
  end

  // Next-state logic; req_valid still high in RESP is the same request, so no accept there
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          cnt_s    = LAT_C;
          if (LAT_C == {LAT_W{1'b0}}) begin
            state_s = RESP;
          end else begin
            state_s = WAIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        cnt_s = cnt_r - LAT_W'(1);
        if (cnt_r <= LAT_W'(1)) begin
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // With zero wait states the read is launched straight from the live request address.
  assign rd_idx_s  = (state_r == IDLE) ? req_idx_s : idx_r;
  assign in_resp_s = (state_r == RESP);
  assign wr_en_s   = in_resp_s & write_r & ~misalign_r;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk    (clk),
    .wr_en  (wr_en_s),
    .wr_idx (idx_r),
    .wr_data(wdata_r),
    .rd_idx (rd_idx_s),
    .rd_data(rd_data_s)
  );

  assign req_ready    = (state_r == IDLE);
  assign resp_valid   = in_resp_s;
  assign stall        = ((state_r == IDLE) & req_valid) | (state_r == WAIT);
  assign misalign_err = in_resp_s & misalign_r;
  assign resp_rdata   = (in_resp_s & ~write_r & ~misalign_r) ? rd_data_s : {WORD_W{1'b0}};

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: two instances (LATENCY 2 and LATENCY 0) checked against
// a word-array reference model with directed scenarios followed by randomized traffic.
module tb_data_memory_responder;

  logic        clk;
  logic        reset;
  logic        v   [2];
  logic        wr  [2];
  logic [31:0] a   [2];
  logic [31:0] d   [2];
  logic        rdy [2];
  logic        rv  [2];
  logic [31:0] rd  [2];
  logic        st  [2];
  logic        me  [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [2][256];

  data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut_lat2 (
    .clk(clk), .reset(reset),
    .req_valid(v[0]), .req_write(wr[0]), .req_addr(a[0]), .req_wdata(d[0]),
    .req_ready(rdy[0]), .resp_valid(rv[0]), .resp_rdata(rd[0]),
    .stall(st[0]), .misalign_err(me[0])
  );

  data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_dut_lat0 (
    .clk(clk), .reset(reset),
    .req_valid(v[1]), .req_write(wr[1]), .req_addr(a[1]), .req_wdata(d[1]),
    .req_ready(rdy[1]), .resp_valid(rv[1]), .resp_rdata(rd[1]),
    .stall(st[1]), .misalign_err(me[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit misalign_model(input logic [31:0] addr);
`ifdef DMEM_MISALIGN_CHECK_EN
    return (addr % 4) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_idle(input int k);
    chk("idle_req_ready", 32'(rdy[k]), 32'd1);
    chk("idle_resp_valid", 32'(rv[k]), 32'd0);
    chk("idle_resp_rdata", rd[k], 32'd0);
    chk("idle_stall", 32'(st[k]), 32'd0);
    chk("idle_misalign_err", 32'(me[k]), 32'd0);
  endtask

  // One complete access; entered and left #1 after a rising edge with the DUT idle.
  task automatic run_txn(input int k, input logic wr_i, input logic [31:0] addr_i,
                         input logic [31:0] wd_i);
    int          idx, lat, cyc, stl;
    bit          mis, done;
    logic [31:0] exp_rd;
    lat    = (k == 0) ? 2 : 0;
    idx    = int'((addr_i / 4) % 256);
    mis    = misalign_model(addr_i);
    exp_rd = (wr_i || mis) ? 32'd0 : mem_m[k][idx];
    v[k] = 1'b1; wr[k] = wr_i; a[k] = addr_i; d[k] = wd_i;
    cyc = 0; stl = 0; done = 1'b0;
    while (!done && cyc <= 20) begin
      @(negedge clk);
      if (rv[k]) begin
        done = 1'b1;
        chk("resp_latency", cyc, lat + 1);
        chk("stall_cycles", stl, lat + 1);
        chk("stall_in_resp", 32'(st[k]), 32'd0);
        chk("resp_rdata", rd[k], exp_rd);
        chk("misalign_err", 32'(me[k]), 32'(mis));
      end else if (st[k]) begin
        stl++;
      end
      @(posedge clk); #1;
      if (cyc == 0) begin
        // post-accept input changes must be ignored
        v[k] = 1'b0; wr[k] = 1'($urandom_range(0, 1)); a[k] = $urandom; d[k] = $urandom;
      end
      cyc++;
    end
    if (!done) chk("resp_timeout", 32'd0, 32'd1);
    if (wr_i && !mis) mem_m[k][idx] = wd_i;
    @(negedge clk);
    chk("ready_after_resp", 32'(rdy[k]), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int          pulses;
    logic [31:0] x1, x2, addr;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      v[k] = 1'b0; wr[k] = 1'b0; a[k] = 32'd0; d[k] = 32'd0;
    end
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle(0);
    check_idle(1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Give words 0..15 of both arrays known contents
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++)
        run_txn(k, 1'b1, 32'(i * 4), $urandom);

    // Reset in the middle of a store's wait states: store is dropped
    v[0] = 1'b1; wr[0] = 1'b1; a[0] = 32'h10; d[0] = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    v[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_idle(0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    run_txn(0, 1'b0, 32'h10, 32'd0);

    // Store then load at 0x20
    run_txn(0, 1'b1, 32'h20, 32'hDEAD_BEEF);
    run_txn(0, 1'b0, 32'h20, 32'd0);

    // Zero wait states
    run_txn(1, 1'b1, 32'h0, 32'hCAFE_0001);
    run_txn(1, 1'b0, 32'h0, 32'd0);

    // Address aliasing beyond the array depth
    run_txn(0, 1'b1, 32'h400, 32'h1234);
    run_txn(0, 1'b0, 32'h0, 32'd0);

    // req_valid held across two requests; the second (a load) picks up inputs changed in WAIT
    x1 = 32'h5A5A_0001; x2 = 32'hA5A5_0002;
    v[0] = 1'b1; wr[0] = 1'b1; a[0] = 32'h30; d[0] = x1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("hold_resp_valid", 32'(rv[0]), 32'((c == 3) || (c == 7)));
      if (rv[0]) pulses++;
      if (c == 4) chk("hold_reaccept_ready", 32'(rdy[0]), 32'd1);
      if (c == 7) chk("hold_second_rdata", rd[0], x1);
      @(posedge clk); #1;
      if (c == 0) begin wr[0] = 1'b0; d[0] = x2; end
      if (c == 7) v[0] = 1'b0;
    end
    chk("hold_pulse_count", pulses, 32'd2);
    mem_m[0][12] = x1;
    @(negedge clk);
    chk("hold_ready_end", 32'(rdy[0]), 32'd1);
    @(posedge clk); #1;

    // Misaligned store at 0x22 followed by aligned load of 0x20
    run_txn(0, 1'b1, 32'h22, 32'h0BAD_F00D);
    run_txn(0, 1'b0, 32'h20, 32'd0);

    // Randomized traffic over the initialized words with aliased and offset addresses
    for (int n = 0; n < 40; n++) begin
      addr = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15) * 4)
             | 32'($urandom_range(0, 3));
      run_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
